// File: rtl/fc_pkg.sv
// Shared types and fixed-point helpers for the fully-connected layer engine.
package fc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StMac,
        StFinish,
        StEmit,
        StDone
    } state_e;

    localparam int unsigned WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Round half up at the binary point, then clamp into a signed data_w-bit range.
    function automatic wide_t sat_round(input wide_t acc, input int unsigned frac,
                                        input int unsigned data_w);
        wide_t one;
        wide_t r;
        wide_t max_v;
        wide_t min_v;
        one   = wide_t'(1);
        r     = (acc + (one <<< (frac - 1))) >>> frac;
        max_v = (one <<< (data_w - 1)) - one;
        min_v = ~max_v;
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

    function automatic wide_t relu(input wide_t x);
        return (x < wide_t'(0)) ? wide_t'(0) : x;
    endfunction

endpackage

// File: rtl/fc_lane.sv
// One output neuron: bias preload, multiply-accumulate over the input vector and a
// registered rounded, optionally rectified, saturated result.
module fc_lane
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40,
    parameter bit          RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     mac_en,
    input  logic                     finish,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [DATA_W-1:0] result
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] result_q, result_d;
    logic signed [PROD_W-1:0] prod;
    wide_t                    rounded;

    assign prod = PROD_W'(in_data) * PROD_W'(weight);

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = ACC_W'(bias) <<< FRAC_BITS;
        end else if (mac_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        // Clamping is monotone, so rectifying after saturation matches rectify-then-saturate.
        rounded = sat_round(WIDE_W'(acc_q), FRAC_BITS, DATA_W);
        if (RELU_EN) begin
            rounded = relu(rounded);
        end
        result_d = finish ? rounded[DATA_W-1:0] : result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer: LANES neurons per pass over the activation buffer, results
// streamed out with valid/ready. Weights and biases are loaded through the cfg port.
module fc_layer_par
    import fc_pkg::*;
#(
    parameter int unsigned IN_SIZE   = 120,
    parameter int unsigned OUT_SIZE  = 10,
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40,
    parameter bit          RELU_EN   = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(IN_SIZE)-1:0]            in_addr,
    input  logic signed [DATA_W-1:0]              in_data,
    input  logic                                  cfg_we,
    input  logic                                  cfg_sel,
    input  logic [$clog2(IN_SIZE*OUT_SIZE)-1:0]   cfg_addr,
    input  logic signed [DATA_W-1:0]              cfg_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [DATA_W-1:0]              out_data,
    output logic [$clog2(OUT_SIZE)-1:0]           out_addr
);
    localparam int unsigned IN_AW  = $clog2(IN_SIZE);
    localparam int unsigned OUT_AW = $clog2(OUT_SIZE);
    localparam int unsigned CFG_AW = $clog2(IN_SIZE * OUT_SIZE);
    localparam int unsigned CFG_CW = CFG_AW + 1;
    localparam int unsigned GROUPS = OUT_SIZE / LANES;
    localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned L_W    = (LANES > 1) ? $clog2(LANES) : 1;

    state_e           state_q, state_d;
    logic [IN_AW-1:0] k_q, k_d;
    logic [G_W-1:0]   g_q, g_d;
    logic [L_W-1:0]   e_q, e_d;
    logic             load, mac_en, finish;
    logic             last_k, last_lane, last_group;

    logic signed [DATA_W-1:0] w_mem    [IN_SIZE*OUT_SIZE];
    logic signed [DATA_W-1:0] b_mem    [OUT_SIZE];
    logic signed [DATA_W-1:0] lane_res [LANES];

    assign last_k     = (k_q == IN_AW'(IN_SIZE - 1));
    assign last_lane  = (e_q == L_W'(LANES - 1));
    assign last_group = (g_q == G_W'(GROUPS - 1));

    // Parameter memories accept writes only while idle and survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == StIdle) begin
            if (!cfg_sel && {1'b0, cfg_addr} < CFG_CW'(IN_SIZE * OUT_SIZE)) begin
                w_mem[cfg_addr] <= cfg_data;
            end else if (cfg_sel && {1'b0, cfg_addr} < CFG_CW'(OUT_SIZE)) begin
                b_mem[cfg_addr[OUT_AW-1:0]] <= cfg_data;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [OUT_AW-1:0] b_idx;
        logic [CFG_AW-1:0] w_idx;

        assign b_idx = OUT_AW'(32'(g_q) * LANES + l);
        assign w_idx = CFG_AW'(32'(b_idx) * IN_SIZE + 32'(k_q));

        fc_lane #(
            .DATA_W   (DATA_W),
            .FRAC_BITS(FRAC_BITS),
            .ACC_W    (ACC_W),
            .RELU_EN  (RELU_EN)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .mac_en (mac_en),
            .finish (finish),
            .bias   (b_mem[b_idx]),
            .in_data(in_data),
            .weight (w_mem[w_idx]),
            .result (lane_res[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            g_q     <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            g_q     <= g_d;
            e_q     <= e_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        e_d     = e_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    k_d     = '0;
                    g_d     = '0;
                    e_d     = '0;
                end
            end
            StFetch: state_d = StMac;
            StMac: begin
                k_d = k_q + 1'b1;
                if (last_k) begin
                    k_d     = '0;
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StEmit;
            StEmit: begin
                if (out_ready) begin
                    if (last_lane) begin
                        e_d = '0;
                        if (last_group) begin
                            state_d = StDone;
                        end else begin
                            g_d     = g_q + 1'b1;
                            state_d = StFetch;
                        end
                    end else begin
                        e_d = e_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        out_valid = (state_q == StEmit);
        load      = (state_q == StFetch);
        mac_en    = (state_q == StMac);
        finish    = (state_q == StFinish);
        // Read one index ahead so in_data for index k arrives in MAC cycle k.
        in_addr   = '0;
        if (state_q == StMac && !last_k) begin
            in_addr = k_q + 1'b1;
        end
        out_data  = lane_res[e_q];
        out_addr  = OUT_AW'(32'(g_q) * LANES + 32'(e_q));
    end

endmodule

// File: tb/tb_fc_layer_par.sv
// Directed bench for fc_layer_par: two instances (ReLU on/off) share stimulus and are
// checked against a plain arithmetic model of the layer on every output handshake.
module tb_fc_layer_par;

    localparam int NI = 4;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cfg_we = 1'b0;
    logic cfg_sel = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic signed [15:0] cfg_data = '0;
    logic out_ready = 1'b1;

    logic busy_r, done_r, ov_r, busy_l, done_l, ov_l;
    logic [1:0] ia_r, ia_l, oa_r, oa_l;
    logic signed [15:0] id_r, id_l, od_r, od_l;

    int w_m [NI*NO];
    int b_m [NO];
    int act [NI];
    int rec_r [NO];
    int rec_l [NO];
    int idx_r, idx_l;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fc_layer_par #(.IN_SIZE(NI), .OUT_SIZE(NO), .LANES(2), .DATA_W(16), .FRAC_BITS(8),
                   .ACC_W(40), .RELU_EN(1'b1)) dut_relu (
        .clk(clk), .reset(reset), .start(start), .busy(busy_r), .done(done_r),
        .in_addr(ia_r), .in_data(id_r), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(ov_r), .out_ready(out_ready),
        .out_data(od_r), .out_addr(oa_r));

    fc_layer_par #(.IN_SIZE(NI), .OUT_SIZE(NO), .LANES(2), .DATA_W(16), .FRAC_BITS(8),
                   .ACC_W(40), .RELU_EN(1'b0)) dut_lin (
        .clk(clk), .reset(reset), .start(start), .busy(busy_l), .done(done_l),
        .in_addr(ia_l), .in_data(id_l), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(ov_l), .out_ready(out_ready),
        .out_data(od_l), .out_addr(oa_l));

    // Activation buffer with the fixed one-cycle read latency.
    always @(posedge clk) begin
        id_r <= 16'(act[ia_r]);
        id_l <= 16'(act[ia_l]);
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint model(input int j, input bit relu_on);
        longint s;
        s = longint'(b_m[j]) * 256;
        for (int i = 0; i < NI; i++) s += longint'(act[i]) * longint'(w_m[j*NI+i]);
        s = (s + 128) >>> 8;
        if (relu_on && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_ready) begin
            if (ov_r) begin
                check("relu_addr", longint'(oa_r), longint'(idx_r));
                check("relu_data", longint'(od_r), model(idx_r % NO, 1'b1));
                rec_r[oa_r] = int'(od_r);
                idx_r++;
            end
            if (ov_l) begin
                check("lin_addr", longint'(oa_l), longint'(idx_l));
                check("lin_data", longint'(od_l), model(idx_l % NO, 1'b0));
                rec_l[oa_l] = int'(od_l);
                idx_l++;
            end
        end
    end

    task automatic cfg_pulse(input bit sel, input int addr, input int val);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_addr = 4'(addr);
        cfg_data = 16'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_w(input int j, input int i, input int val);
        w_m[j*NI+i] = val;
        cfg_pulse(1'b0, j*NI+i, val);
    endtask

    task automatic set_b(input int j, input int val);
        b_m[j] = val;
        cfg_pulse(1'b1, j, val);
    endtask

    task automatic fill(input int wv, input int bv, input int av);
        for (int j = 0; j < NO; j++) begin
            for (int i = 0; i < NI; i++) set_w(j, i, wv);
            set_b(j, bv);
        end
        for (int i = 0; i < NI; i++) act[i] = av;
    endtask

    // One inference; optional stall at first output, abort by reset, write with start.
    task automatic run(input int stall_n, input int abort_cyc, input bit sw_en,
                       input int sw_val, input int exp_cyc);
        int cyc;
        bit got_done;
        bit stalled;
        bit aborted;
        logic [1:0] a0;
        logic signed [15:0] d0;
        cyc = 0; got_done = 0; stalled = 0; aborted = 0;
        idx_r = 0; idx_l = 0;
        for (int j = 0; j < NO; j++) begin rec_r[j] = 99999; rec_l[j] = 99999; end
        if (sw_en) begin
            w_m[0] = sw_val;
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_data = 16'(sw_val);
        end
        start = 1'b1;
        while (!got_done && !aborted && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            cfg_we = 1'b0;
            if (cyc == 1) check("busy_after_start", longint'(busy_r), 1);
            if (done_r) begin
                got_done = 1;
            end else if (abort_cyc > 0 && cyc == 2) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_data = 16'h1234;
            end else if (abort_cyc > 0 && cyc == abort_cyc) begin
                reset = 1'b1;
                #1;
                check("abort_busy", longint'(busy_r | busy_l), 0);
                check("abort_valid", longint'(ov_r | ov_l), 0);
                check("abort_done", longint'(done_r | done_l), 0);
                check("partial_outs", longint'(idx_r), 2);
                @(posedge clk); #1;
                reset = 1'b0;
                aborted = 1;
            end else if (stall_n > 0 && !stalled && ov_r) begin
                stalled = 1;
                out_ready = 1'b0;
                a0 = oa_r;
                d0 = od_r;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    cyc++;
                    check("stall_valid", longint'(ov_r), 1);
                    check("stall_addr", longint'(oa_r), longint'(a0));
                    check("stall_data", longint'(od_r), longint'(d0));
                end
                out_ready = 1'b1;
            end
        end
        if (!aborted) begin
            check("cycles", longint'(cyc), longint'(exp_cyc));
            check("done_lin", longint'(done_l), 1);
            check("outs_relu", longint'(idx_r), NO);
            check("outs_lin", longint'(idx_l), NO);
            @(posedge clk); #1;
            check("done_pulse", longint'(done_r), 0);
            check("busy_idle", longint'(busy_r), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) act[i] = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", longint'(busy_r), 0);
        check("rst_done", longint'(done_r), 0);
        check("rst_valid", longint'(ov_r), 0);
        check("rst_in_addr", longint'(ia_r), 0);
        check("rst_out_data", longint'(od_r), 0);
        check("rst_out_addr", longint'(oa_r), 0);
        reset = 1'b0;

        // Uniform: 4 * 1.0 * 1.0 = 4.0 -> 1024.
        fill(256, 0, 256);
        run(0, 0, 1'b0, 0, 17);
        for (int j = 0; j < NO; j++) begin
            check("uniform_relu", longint'(rec_r[j]), 1024);
            check("uniform_lin", longint'(rec_l[j]), 1024);
        end

        // Rounding half up at the binary point.
        fill(0, 0, 0);
        act[0] = 1;
        set_w(0, 0, 128);
        run(0, 0, 1'b0, 0, 17);
        check("round_up", longint'(rec_l[0]), 1);
        run(0, 0, 1'b1, 127, 17);
        check("round_down", longint'(rec_l[0]), 0);
        check("round_down_relu", longint'(rec_r[0]), 0);

        // Saturation in both directions.
        fill(32767, 32767, 32767);
        run(0, 0, 1'b0, 0, 17);
        check("sat_pos_lin", longint'(rec_l[0]), 32767);
        check("sat_pos_relu", longint'(rec_r[3]), 32767);
        for (int i = 0; i < NI; i++) act[i] = -32768;
        run(0, 0, 1'b0, 0, 17);
        check("sat_neg_lin", longint'(rec_l[0]), -32768);
        check("sat_neg_relu", longint'(rec_r[0]), 0);

        // Mixed-sign data with a five-cycle stall on the first output.
        for (int j = 0; j < NO; j++) begin
            for (int i = 0; i < NI; i++) set_w(j, i, (i + 1) * 64 - j * 96);
            set_b(j, j * 100 - 150);
        end
        act[0] = 256; act[1] = 512; act[2] = -256; act[3] = 128;
        run(5, 0, 1'b0, 0, 22);

        // Bias-only path; an out-of-range bias write must not alias.
        fill(0, 0, 0);
        for (int j = 0; j < NO; j++) set_b(j, j * 256 - 512);
        cfg_pulse(1'b1, 4, 1000);
        run(0, 0, 1'b0, 0, 17);
        check("bias0_lin", longint'(rec_l[0]), -512);
        check("bias1_lin", longint'(rec_l[1]), -256);
        check("bias2_lin", longint'(rec_l[2]), 0);
        check("bias3_lin", longint'(rec_l[3]), 256);
        check("bias0_relu", longint'(rec_r[0]), 0);
        check("bias3_relu", longint'(rec_r[3]), 256);

        // Abort during group 1 MAC with a write attempted while busy, then rerun.
        fill(256, 0, 256);
        run(0, 11, 1'b0, 0, 17);
        run(0, 0, 1'b0, 0, 17);
        for (int j = 0; j < NO; j++) check("rerun_relu", longint'(rec_r[j]), 1024);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_par.md
Name: fc_layer_par

Overview:
- Parametrised fully-connected layer engine. Computes out[j] = sat(round((bias[j]<<FRAC + sum_i in[i]*W[j][i]) >>> FRAC)), with optional ReLU.
- Evaluates LANES output neurons in parallel per pass over the input vector.
- Weights and biases are loaded through a write port, not self-initialised.
- Sits after the last pooling/flatten stage. Reads activations from an external buffer and streams results with valid/ready.

Parameters:
- IN_SIZE, 120, input vector length (>=2).
- OUT_SIZE, 10, output neurons; must be a multiple of LANES.
- LANES, 2, neurons computed concurrently (1..OUT_SIZE).
- DATA_W, 16, signed fixed-point width of activations, weights, biases and outputs.
- FRAC_BITS, 8, fractional bits (>=1).
- ACC_W, 40, signed accumulator width (>= 2*DATA_W + clog2(IN_SIZE) + 1).
- RELU_EN, 1, 1 = clamp negative results to 0 before output.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  pulse; begins one inference
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- in_addr  out  clog2(IN_SIZE)  activation read address
- in_data  in  DATA_W  signed activation; valid exactly 1 cycle after in_addr
- cfg_we  in  1  parameter write strobe
- cfg_sel  in  1  0 = weight, 1 = bias
- cfg_addr  in  clog2(IN_SIZE*OUT_SIZE)  weight index j*IN_SIZE+i, or bias index j
- cfg_data  in  DATA_W  signed value to write
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts when valid&&ready
- out_data  out  DATA_W  signed result
- out_addr  out  clog2(OUT_SIZE)  neuron index j

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy, done, out_valid = 0; in_addr, out_data, out_addr = 0; all counters and accumulators 0.
  - Weight and bias memories are NOT cleared.
- States: IDLE -> FETCH -> MAC -> FINISH -> EMIT -> (FETCH | DONE) -> IDLE.
- IDLE: start=1 latches group g=0, sets busy, goes to FETCH.
- FETCH (1 cycle):
  - in_addr=0.
  - Each lane l loads acc[l] = sign-extended bias[g*LANES+l] << FRAC_BITS.
- MAC (IN_SIZE cycles, pipelined):
  - Cycle k issues in_addr=k+1 (while k+1<IN_SIZE) and consumes in_data for index k.
  - acc[l] += in_data * W[g*LANES+l][k]; full 2*DATA_W product, sign-extended to ACC_W.
- FINISH (1 cycle):
  - r = (acc + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, i.e. round half up.
  - If RELU_EN and r<0, r=0.
  - Saturate to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - Store into lane result registers.
- EMIT:
  - Presents lanes 0..LANES-1 in order: out_addr = g*LANES+l, out_valid=1.
  - Advances only on out_valid&&out_ready. out_data/out_addr hold stable while stalled.
  - After the last lane handshake: if g<OUT_SIZE/LANES-1 then g++ and go to FETCH (out_valid drops); else go to DONE.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Latency per group: 2 + IN_SIZE cycles plus >= LANES emit cycles. Total with out_ready=1: (OUT_SIZE/LANES)*(IN_SIZE+2+LANES)+1.
- start while busy is ignored.
- cfg_we is honoured only in IDLE and ignored while busy. Out-of-range cfg_addr is ignored.
- A write and a start in the same IDLE cycle: the write lands and the inference uses the new value.
- Reset mid-inference aborts immediately. No done pulse; partial outputs already handshaked stand.
- in_data is sampled without a valid signal; the source must honour the fixed 1-cycle read latency.

Decomposition:
- Shared package fc_pkg: state encoding, rounding/saturation function sat_round(acc, FRAC_BITS, DATA_W), ReLU helper.
- One sub-module fc_lane: per-lane accumulator with bias preload, MAC enable and FINISH output. Instantiated LANES times via generate.
- Weight/bias storage stays in the top as arrays indexed per lane.

Test Plan:
- IN_SIZE=4, OUT_SIZE=4, LANES=2, FRAC=8; all W=256, in=256, bias=0 -> four outputs 1024, out_addr 0,1,2,3; done after 2*(4+2+2)+1=17 cycles.
- Rounding: in[0]=1, W[0][0]=128, rest 0, bias 0 -> out[0]=1. Same with W=127 -> out[0]=0.
- Saturation: W=0x7FFF, in=0x7FFF, bias=0x7FFF -> out 0x7FFF. With in=-32768, RELU_EN=0 -> out 0x8000; RELU_EN=1 -> out 0.
- Backpressure: hold out_ready=0 for 5 cycles at the first output -> out_valid stays 1, data/addr unchanged; results identical to the unstalled run.
- Bias path: all W=0, bias[j]=j*256-512 with RELU_EN=0 -> outputs -512, -256, 0, 256.
- Reset asserted during MAC of group 1 -> busy, out_valid, done all 0 the same cycle. A fresh start reproduces the correct full result using the retained weights. A cfg_we during busy leaves weights unchanged.
